// File: rtl/gate_delay_sequencer.sv
// Propagation-delay sequencer for a 2-input ZN = A1 & ~B1 cell: settles a baseline,
// launches one edge on the selected input and counts clk cycles until synced ZN follows.
module gate_delay_sequencer #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned SETTLE      = 4,
  parameter int unsigned TIMEOUT     = 200,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             path_sel,
  input  logic             pol,
  output logic             a1_drv,
  output logic             b1_drv,
  input  logic             zn_in,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] delay_cnt,
  output logic             timeout,
  output logic             base_err
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_LAUNCH,
    S_MEASURE,
    S_REPORT
  } state_t;

  state_t                 state;
  logic                   path_q;
  logic                   pol_q;
  logic [CNT_W-1:0]       cnt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   zn_s;
  logic                   eb;

  assign zn_s = sync_q[SYNC_STAGES-1];
  // Baseline ZN: A1 path sees ~pol directly, B1 path sees it inverted by the cell.
  assign eb   = path_q ? pol_q : ~pol_q;

  // ZN is asynchronous to clk; bring it in through a plain flop chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= zn_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      path_q    <= 1'b0;
      pol_q     <= 1'b0;
      cnt       <= '0;
      a1_drv    <= 1'b0;
      b1_drv    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      delay_cnt <= '0;
      timeout   <= 1'b0;
      base_err  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            path_q <= path_sel;
            pol_q  <= pol;
            busy   <= 1'b1;
            cnt    <= '0;
            // Side input to its enabling value, selected input to ~pol.
            a1_drv <= path_sel | ~pol;
            b1_drv <= path_sel & ~pol;
            state  <= S_INIT;
          end
        end
        S_INIT: begin
          if (cnt == SETTLE_LAST) begin
            if (zn_s != eb) begin
              base_err  <= 1'b1;
              timeout   <= 1'b0;
              delay_cnt <= '0;
              done      <= 1'b1;
              state     <= S_REPORT;
            end else begin
              state <= S_LAUNCH;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_LAUNCH: begin
          if (path_q) begin
            b1_drv <= pol_q;
          end else begin
            a1_drv <= pol_q;
          end
          cnt   <= '0;
          state <= S_MEASURE;
        end
        S_MEASURE: begin
          if (zn_s != eb) begin
            delay_cnt <= cnt;
            timeout   <= 1'b0;
            base_err  <= 1'b0;
            done      <= 1'b1;
            state     <= S_REPORT;
          end else if (cnt == TIMEOUT_CNT) begin
            delay_cnt <= TIMEOUT_CNT;
            timeout   <= 1'b1;
            base_err  <= 1'b0;
            done      <= 1'b1;
            state     <= S_REPORT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_REPORT: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
